// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    DONE
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned widths have no store form, so a store with funct3[2] set is a no-op too.
  function automatic logic is_noop(input logic load, input logic store, input logic [2:0] funct3);
    return (load == store) || (funct3 == 3'b011) || (funct3 == 3'b110) ||
           (funct3 == 3'b111) || (store && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response bundle and word-only data memory bundle.
interface lsu_req_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned
  );

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction/extension for loads and byte/half merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = rdata;
    if (funct3 == F3_B)
      store_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H)
      store_word[{lane[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, sub-word stores as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  lsu_state_t        state, next_state, first_state;
  logic              accept, req_noop, req_mis, write_strobe;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, wbuf_q, rdata_q;
  logic              mis_q;
  logic [31:0]       load_data, store_word;

  lsu_lane_align u_align (
    .rdata      (mem.mem_read_data),
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The first state of a request is decided from the raw request at acceptance.
  always_comb begin
    accept   = req.req_valid && req.req_ready;
    req_noop = is_noop(req.req_load, req.req_store, req.req_funct3);
    req_mis  = !req_noop && is_misaligned(req.req_funct3, req.req_addr[1:0]);
    if (req_noop || req_mis)        first_state = DONE;
    else if (req.req_load)          first_state = LOAD;
    else if (req.req_funct3 == F3_W) first_state = STORE;
    else                            first_state = RMW_RD;

    next_state = state;
    case (state)
      IDLE:          next_state = accept ? first_state : IDLE;
      LOAD, STORE:   next_state = DONE;
      RMW_RD:        next_state = RMW_WR;
      RMW_WR:        next_state = DONE;
      DONE:          next_state = accept ? first_state : IDLE;
      default:       next_state = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready       = 1'b0;
    mem.mem_read        = 1'b0;
    write_strobe        = 1'b0;
    mem.mem_write_data  = '0;
    case (state)
      IDLE:   req.req_ready = 1'b1;
      LOAD:   mem.mem_read  = 1'b1;
      STORE: begin
        write_strobe       = 1'b1;
        mem.mem_write_data = wdata_q;
      end
      RMW_RD: mem.mem_read  = 1'b1;
      RMW_WR: begin
        write_strobe       = 1'b1;
        mem.mem_write_data = wbuf_q;
      end
      DONE:   req.req_ready = 1'b1;
      default: ;
    endcase
  end

  // A write must not land while reset is held, even if the state has not yet left STORE/RMW_WR.
  assign mem.mem_write   = write_strobe && rst_n;
  assign mem.mem_address = {addr_q[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q             <= '0;
      addr_q               <= '0;
      wdata_q              <= '0;
      wbuf_q               <= '0;
      rdata_q              <= '0;
      mis_q                <= 1'b0;
      req.resp_valid       <= 1'b0;
      req.resp_rdata       <= '0;
      req.resp_misaligned  <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= req.req_funct3;
        addr_q   <= req.req_addr;
        wdata_q  <= req.req_wdata;
        mis_q    <= req_mis;
        rdata_q  <= '0;
      end else if (state == LOAD) begin
        rdata_q  <= load_data;
      end
      if (state == RMW_RD)
        wbuf_q <= store_word;
      // The response is registered out of DONE, so it overlaps a request accepted in DONE.
      req.resp_valid      <= (state == DONE);
      req.resp_rdata      <= (state == DONE) ? rdata_q : '0;
      req.resp_misaligned <= (state == DONE) && mis_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic load_init;
  always #5 clk = ~clk;

  lsu_req_if #(.ADDR_W(32)) rif ();
  lsu_mem_if #(.ADDR_W(32)) mif ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rif.slave),
    .mem   (mif.master)
  );

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];

  assign mif.mem_read_data = dmem[mif.mem_address[7:2]];

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= ref_mem[i];
    end else if (mif.mem_write) begin
      dmem[mif.mem_address[7:2]] <= mif.mem_write_data;
    end
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit modelNoop(bit ld, bit st, int unsigned f3);
    return (ld == st) || f3 == 3 || f3 == 6 || f3 == 7 || (st && f3 >= 4);
  endfunction

  function automatic bit modelMis(int unsigned f3, int unsigned a);
    if (f3 == 1 || f3 == 5) return (a % 2) != 0;
    if (f3 == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(logic [31:0] word, int unsigned f3, int unsigned a);
    logic [31:0] b, h;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      2: return word;
      4: return b;
      5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] modelStore(logic [31:0] word, int unsigned f3, int unsigned a, logic [31:0] wd);
    int unsigned sh;
    if (f3 == 0) begin
      sh = 8 * (a % 4);
      return (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (f3 == 1) begin
      sh = 16 * ((a / 2) % 2);
      return (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic applyStimulus(input bit ld, input bit st, input int unsigned f3, input int unsigned a,
                               input logic [31:0] wd, output logic [31:0] got_rdata, output logic got_mis);
    bit noop, mis;
    int unsigned idx, exp_lat, exp_rd, exp_wr, lat, n_rd, n_wr;
    logic [31:0] exp_rdata, exp_wdata;
    idx = a / 4;
    noop = modelNoop(ld, st, f3);
    mis = !noop && modelMis(f3, a);
    exp_rdata = 0;
    exp_wdata = 0;
    if (noop || mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (ld) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      exp_rdata = modelLoad(ref_mem[idx], f3, a);
    end else if (f3 == 2) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      exp_wdata = wd;
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 1;
      exp_wdata = modelStore(ref_mem[idx], f3, a, wd);
    end

    @(negedge clk);
    checkOutput("ready", rif.req_ready, 1);
    rif.req_valid  = 1'b1;
    rif.req_load   = ld;
    rif.req_store  = st;
    rif.req_funct3 = f3[2:0];
    rif.req_addr   = a;
    rif.req_wdata  = wd;
    @(posedge clk);
    lat = 0; n_rd = 0; n_wr = 0;
    got_rdata = 32'h0;
    got_mis = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rif.req_valid  = 1'b0;
        rif.req_load   = $urandom_range(0, 1);
        rif.req_store  = $urandom_range(0, 1);
        rif.req_funct3 = $urandom_range(0, 7);
        rif.req_addr   = $urandom;
        rif.req_wdata  = $urandom;
      end
      if (mif.mem_read && mif.mem_write) checkOutput("strobe_excl", 1, 0);
      if (mif.mem_read) begin
        n_rd++;
        checkOutput("rd_addr", mif.mem_address, idx * 4);
      end
      if (mif.mem_write) begin
        n_wr++;
        checkOutput("wr_addr", mif.mem_address, idx * 4);
        checkOutput("wr_data", mif.mem_write_data, exp_wdata);
      end
      if (rif.resp_valid) begin
        lat = c - 1;
        got_rdata = rif.resp_rdata;
        got_mis = rif.resp_misaligned;
        break;
      end
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("rdata", got_rdata, exp_rdata);
    checkOutput("misaligned", got_mis, mis);
    checkOutput("reads", n_rd, exp_rd);
    checkOutput("writes", n_wr, exp_wr);
    if (exp_wr != 0) ref_mem[idx] = exp_wdata;
    checkOutput("mem_word", dmem[idx], ref_mem[idx]);
    @(negedge clk);
    checkOutput("resp_pulse", rif.resp_valid, 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, rif.req_ready, 1);
    checkOutput({tag, "_rvalid"}, rif.resp_valid, 0);
    checkOutput({tag, "_rdata"}, rif.resp_rdata, 0);
    checkOutput({tag, "_rmis"}, rif.resp_misaligned, 0);
    checkOutput({tag, "_mrd"}, mif.mem_read, 0);
    checkOutput({tag, "_mwr"}, mif.mem_write, 0);
    checkOutput({tag, "_maddr"}, mif.mem_address, 0);
    checkOutput({tag, "_mwdata"}, mif.mem_write_data, 0);
  endtask

  logic [31:0] r;
  logic        m;

  initial begin
    rst_n = 1'b0;
    load_init = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_load = 1'b0;
    rif.req_store = 1'b0;
    rif.req_funct3 = 3'b0;
    rif.req_addr = 32'h0;
    rif.req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_init = 1'b0;
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    applyStimulus(1, 0, 2, 'h10, 0, r, m);  checkOutput("lw_const", r, 32'h8899AABB);
    applyStimulus(1, 0, 0, 'h13, 0, r, m);  checkOutput("lb_const", r, 32'hFFFFFF88);
    applyStimulus(1, 0, 4, 'h13, 0, r, m);  checkOutput("lbu_const", r, 32'h00000088);
    applyStimulus(1, 0, 1, 'h12, 0, r, m);  checkOutput("lh_const", r, 32'hFFFF8899);
    applyStimulus(1, 0, 5, 'h10, 0, r, m);  checkOutput("lhu_const", r, 32'h0000AABB);
    applyStimulus(0, 1, 0, 'h11, 32'h12345677, r, m);
    applyStimulus(1, 0, 2, 'h10, 0, r, m);  checkOutput("sb_merge_const", r, 32'h889977BB);
    applyStimulus(0, 1, 1, 'h11, 32'h5555, r, m);  checkOutput("sh_mis_const", m, 1);
    applyStimulus(1, 0, 2, 'h12, 0, r, m);  checkOutput("lw_mis_const", m, 1);

    // Reset while the RMW read is in flight.
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_load = 1'b0; rif.req_store = 1'b1;
    rif.req_funct3 = 3'b001; rif.req_addr = 'h12; rif.req_wdata = 32'hCAFE;
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    checkOutput("rmwrd_read", mif.mem_read, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("rst_rmwrd");
    rst_n = 1'b1;
    checkOutput("rst_rmwrd_mem", dmem[4], ref_mem[4]);

    // Reset asserted during the RMW write cycle must suppress the write.
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_load = 1'b0; rif.req_store = 1'b1;
    rif.req_funct3 = 3'b000; rif.req_addr = 'h13; rif.req_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rmwwr_write", mif.mem_write, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmwwr_gated", mif.mem_write, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_rmwwr_mem", dmem[4], ref_mem[4]);

    // sw followed by an lw held valid and accepted in DONE.
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_load = 1'b0; rif.req_store = 1'b1;
    rif.req_funct3 = 3'b010; rif.req_addr = 'h10; rif.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_sw_write", mif.mem_write, 1);
    rif.req_load = 1'b1; rif.req_store = 1'b0; rif.req_wdata = 32'h0;
    @(negedge clk);
    checkOutput("b2b_done_ready", rif.req_ready, 1);
    @(negedge clk);
    rif.req_valid = 1'b0;
    checkOutput("b2b_sw_resp", rif.resp_valid, 1);
    checkOutput("b2b_lw_read", mif.mem_read, 1);
    checkOutput("b2b_lw_addr", mif.mem_address, 32'h10);
    @(negedge clk);
    checkOutput("b2b_gap", rif.resp_valid, 0);
    @(negedge clk);
    checkOutput("b2b_lw_resp", rif.resp_valid, 1);
    checkOutput("b2b_lw_rdata", rif.resp_rdata, 32'hDEADBEEF);
    ref_mem[4] = 32'hDEADBEEF;
    checkOutput("b2b_mem", dmem[4], 32'hDEADBEEF);

    for (int n = 0; n < 250; n++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 255), $urandom, r, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the RV32I core's data memory port. It accepts one load or store request at a time from the pipeline and performs byte/halfword lane extraction with sign or zero extension. The data memory stores whole words only, so sub-word stores are done as a read-modify-write. The block drives the word-only data memory interface (`mem_read`/`mem_write`/address/write data, asynchronous read data) and returns a registered response to the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; the memory word index is `addr[ADDR_W-1:2]`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk`)
- `req_valid`  in  1  pipeline request present
- `req_ready`  out  1  block can accept; the request transfers when `req_valid && req_ready`
- `req_load`  in  1  request is a load
- `req_store`  in  1  request is a store
- `req_funct3`  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, LSB-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load result; 0 for stores and faults
- `resp_misaligned`  out  1  qualifies `resp_valid`; access was misaligned and was not performed
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe, sampled by memory at `posedge clk`
- `mem_address`  out  ADDR_W  word-aligned address (bits [1:0] = 00)
- `mem_write_data`  out  32  full word to write
- `mem_read_data`  in  32  combinational read data, valid in the same cycle `mem_read` is high

## Operation
- Memory is little-endian: byte lane n is `[8n+7:8n]`. The lane is `addr[1:0]`; the halfword lane is `addr[1]`.
- FSM states:
  - IDLE: `req_ready=1`.
  - LOAD: `mem_read=1`. The extracted and extended data is registered.
  - STORE: `mem_write=1`, with `req_wdata` as the full word.
  - RMW_RD: `mem_read=1`. The read word, with the new byte/half merged in, is captured into the write buffer.
  - RMW_WR: `mem_write=1`, writing the write buffer.
  - DONE: `resp_valid=1`, and `req_ready=1`.
- Acceptance in IDLE or DONE registers the request.
- The next state is chosen at acceptance:
  - LOAD for loads.
  - STORE for sw.
  - RMW_RD for sb/sh.
  - DONE directly for misaligned or no-op requests.
- The sequence continues LOAD/STORE → DONE and RMW_RD → RMW_WR → DONE.
- DONE goes to IDLE, unless a new request is accepted in DONE, in which case it goes to that request's first state.
- Misaligned: h/hu/sh with `addr[0]=1`, or w/sw with `addr[1:0]≠0`. Such a request goes straight to DONE with `resp_misaligned=1` and no memory strobe.
- No-op: `req_load==req_store`, or `req_funct3` is 011, 110 or 111. It goes to DONE with `resp_rdata=0`, `resp_misaligned=0` and no strobe.
- Load extension: b/h are sign-extended from bit 7/15 of the lane; bu/hu are zero-extended; w passes the word through.
- Store merge: sb replaces lane `addr[1:0]` with `req_wdata[7:0]`; sh replaces lane `addr[1]` with `req_wdata[15:0]`; all other bytes are preserved.
- `req_*` inputs are ignored whenever `req_ready=0`.

## Timing
- Request accepted at edge 0. `resp_valid` is high in the cycle after edge:
  - 2 for loads and sw;
  - 3 for sb/sh;
  - 1 for misaligned or no-op requests.
- `mem_read`/`mem_write` are decoded from the state, high for exactly one cycle per access, and never high together.
- `mem_write` is gated with `rst_n`: reset asserted during RMW_WR or STORE must not write.
- Reset: state→IDLE. `resp_valid`, `resp_rdata`, `resp_misaligned`, `mem_read`, `mem_write`, `mem_address` and `mem_write_data` are all 0; `req_ready=1` from the first cycle after reset.
- Reset mid-operation abandons the access; a partial RMW leaves memory unchanged.
- Peak throughput is one load per 2 cycles, by accepting in DONE.
- `resp_*` are registered. There is no backpressure on responses; the pipeline must consume `resp_valid` in the cycle it is high.

## Structure
- `lsu_pkg`:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - `lsu_state_t` enum {IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE};
  - function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `lsu_lane_align`: purely combinational. It takes read word, funct3, lane and store data, and outputs the extended load value and the merged store word.
- Top level: FSM plus request, write-buffer and response registers.

## Test plan
- Preload word 0x10 = 0x8899AABB; lw 0x10 → `resp_rdata=0x8899AABB` two cycles after acceptance; `mem_read` high for one cycle with `mem_address=0x10`.
- Sub-word loads from word 0x10 = 0x8899AABB:
  - lb 0x13 → 0xFFFFFF88;
  - lbu 0x13 → 0x00000088;
  - lh 0x12 → 0xFFFF8899;
  - lhu 0x10 → 0x0000AABB.
- sb 0x11, `req_wdata=0x12345677` → `mem_read` one cycle, then `mem_write` with 0x889977BB; a subsequent lw 0x10 returns 0x889977BB; `resp_valid` three cycles after acceptance.
- sh 0x11 and lw 0x12 → `resp_valid` with `resp_misaligned=1` in the cycle after acceptance; `mem_read` and `mem_write` stay 0.
- sh 0x12 with reset asserted in the RMW_RD cycle → no `mem_write`; word 0x10 unchanged; `req_ready=1` and outputs 0 after reset.
- Back-to-back: lw 0x10 held valid so it is accepted in DONE after sw 0x10 = 0xDEADBEEF → returns 0xDEADBEEF; no idle cycle between the two requests.
